// File: rtl/ysyx_22050078_ifu_if.sv
// Fetch-side bundle of ysyx_22050078_ifu: instruction-memory address and
// data handshakes, decode-stage handshake, redirect input and error flag.
// Member names match the original flat port names so existing
// connections map one-to-one.
interface ysyx_22050078_ifu_if #(
    parameter int PC_WIDTH = 64
);
    logic                o_ar_valid;
    logic                i_ar_ready;
    logic [PC_WIDTH-1:0] o_ar_addr;
    logic                i_r_valid;
    logic                o_r_ready;
    logic [31:0]         i_r_data;
    logic [31:0]         o_inst;
    logic [PC_WIDTH-1:0] o_pc;
    logic                o_inst_valid;
    logic                i_inst_ready;
    logic                i_redirect;
    logic [PC_WIDTH-1:0] i_redirect_pc;
    logic                o_fetch_err;

    // IFU side
    modport master (
        output o_ar_valid, o_ar_addr, o_r_ready, o_inst, o_pc, o_inst_valid, o_fetch_err,
        input  i_ar_ready, i_r_valid, i_r_data, i_inst_ready, i_redirect, i_redirect_pc
    );

    // Memory / decode / PCU side
    modport slave (
        input  o_ar_valid, o_ar_addr, o_r_ready, o_inst, o_pc, o_inst_valid, o_fetch_err,
        output i_ar_ready, i_r_valid, i_r_data, i_inst_ready, i_redirect, i_redirect_pc
    );
endinterface

// File: rtl/ysyx_22050078_ifu.sv
// Instruction fetch unit: one outstanding fetch at a time, IDLE -> ADDR ->
// DATA -> OUT -> ADDR. A redirect reloads the pc in any state; a fetch
// already in flight is marked with flush and its data discarded.
// Optional macro IFU_MISALIGN_CHK_EN: flag a misaligned pc (sticky
// o_fetch_err) and stall in ADDR until an aligned redirect.
module ysyx_22050078_ifu #(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(64'h8000_0000)
) (
    input logic                 i_clk,
    input logic                 i_rst,
    ysyx_22050078_ifu_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        OUT
    } state_t;

    state_t              state, state_next;
    logic [PC_WIDTH-1:0] pc, pc_next;
    logic                flush, flush_next;
    logic [31:0]         inst_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic                load_buf;
    logic                ar_valid;

`ifdef IFU_MISALIGN_CHK_EN
    logic err, err_next;

    // Address request is suppressed while a misalignment is flagged
    always_comb begin
        ar_valid = (state == ADDR) && !err;
    end
`else
    always_comb begin
        ar_valid = (state == ADDR);
    end
`endif

    // Next state, next pc, flush tracking and output-buffer load
    always_comb begin
        state_next = state;
        pc_next    = pc;
        flush_next = flush;
        load_buf   = 1'b0;
        case (state)
            IDLE: state_next = ADDR;
            ADDR: begin
                if (ar_valid && bus.i_ar_ready) begin
                    state_next = DATA;
                    flush_next = bus.i_redirect;
                end
            end
            DATA: begin
                if (bus.i_r_valid) begin
                    if (flush || bus.i_redirect) begin
                        state_next = ADDR;
                        flush_next = 1'b0;
                    end else begin
                        state_next = OUT;
                        load_buf   = 1'b1;
                    end
                end else if (bus.i_redirect) begin
                    flush_next = 1'b1;
                end
            end
            OUT: begin
                if (bus.i_redirect) begin
                    state_next = ADDR;
                end else if (bus.i_inst_ready) begin
                    state_next = ADDR;
                    pc_next    = pc + PC_WIDTH'(4);
                end
            end
            default: state_next = IDLE;
        endcase
        // Redirect wins over the sequential increment
        if (bus.i_redirect) begin
            pc_next = bus.i_redirect_pc;
        end
    end

`ifdef IFU_MISALIGN_CHK_EN
    // Sticky error: set on entering/remaining in ADDR with a misaligned pc,
    // cleared only by a redirect to an aligned target
    always_comb begin
        err_next = err;
        if (bus.i_redirect && (bus.i_redirect_pc[1:0] == 2'b00)) begin
            err_next = 1'b0;
        end
        if ((state_next == ADDR) && (pc_next[1:0] != 2'b00)) begin
            err_next = 1'b1;
        end
    end

    // Error flag register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err <= 1'b0;
        end else begin
            err <= err_next;
        end
    end

    assign bus.o_fetch_err = err;
`else
    assign bus.o_fetch_err = 1'b0;
`endif

    // State, pc, flush and output buffer registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            flush  <= 1'b0;
            inst_q <= '0;
            pc_q   <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            flush <= flush_next;
            if (load_buf) begin
                inst_q <= bus.i_r_data;
                pc_q   <= pc;
            end
        end
    end

    assign bus.o_ar_valid   = ar_valid;
    assign bus.o_ar_addr    = pc;
    assign bus.o_r_ready    = (state == DATA);
    assign bus.o_inst_valid = (state == OUT);
    assign bus.o_inst       = inst_q;
    assign bus.o_pc         = pc_q;
endmodule

// File: tb/tb_ysyx_22050078_ifu.sv
// Directed testbench for ysyx_22050078_ifu. Inputs change 1ns after the
// rising edge; outputs are compared in the same window, before the next edge.
module tb_ysyx_22050078_ifu;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    ysyx_22050078_ifu_if #(.PC_WIDTH(64)) bus ();

    ysyx_22050078_ifu #(
        .PC_WIDTH(64),
        .RESET_PC(64'h8000_0000)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ADDR cycle: expect a request at exp_addr, accept it
    task automatic do_addr(input logic [63:0] exp_addr);
        check("ar_valid", 64'(bus.o_ar_valid), 64'd1);
        check("ar_addr", bus.o_ar_addr, exp_addr);
        check("inst_valid_in_addr", 64'(bus.o_inst_valid), 64'd0);
        bus.i_ar_ready = 1'b1;
        step();
        bus.i_ar_ready = 1'b0;
    endtask

    // DATA cycle: expect r_ready, return data
    task automatic do_data(input logic [31:0] data);
        check("r_ready", 64'(bus.o_r_ready), 64'd1);
        check("ar_valid_in_data", 64'(bus.o_ar_valid), 64'd0);
        bus.i_r_valid = 1'b1;
        bus.i_r_data  = data;
        step();
        bus.i_r_valid = 1'b0;
    endtask

    // OUT cycle: expect buffered instruction, consume it
    task automatic do_out(input logic [63:0] exp_pc, input logic [31:0] exp_inst);
        check("inst_valid", 64'(bus.o_inst_valid), 64'd1);
        check("inst", 64'(bus.o_inst), 64'(exp_inst));
        check("pc", bus.o_pc, exp_pc);
        check("ar_valid_in_out", 64'(bus.o_ar_valid), 64'd0);
        bus.i_inst_ready = 1'b1;
        step();
        bus.i_inst_ready = 1'b0;
    endtask

    // ar_valid and inst_valid must never be high together
    always @(negedge clk) begin
        if (!rst && bus.o_ar_valid && bus.o_inst_valid) begin
            check("ar_inst_exclusive", 64'd1, 64'd0);
        end
    end

    initial begin
        n_checks          = 0;
        n_pass            = 0;
        rst               = 1'b1;
        bus.i_ar_ready    = 1'b0;
        bus.i_r_valid     = 1'b0;
        bus.i_r_data      = '0;
        bus.i_inst_ready  = 1'b0;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;

        // Reset state
        step();
        step();
        check("rst_ar_valid", 64'(bus.o_ar_valid), 64'd0);
        check("rst_r_ready", 64'(bus.o_r_ready), 64'd0);
        check("rst_inst_valid", 64'(bus.o_inst_valid), 64'd0);
        check("rst_inst", 64'(bus.o_inst), 64'd0);
        check("rst_pc", bus.o_pc, 64'd0);
        check("rst_fetch_err", 64'(bus.o_fetch_err), 64'd0);

        // First cycle after release is still idle; request in the second
        rst = 1'b0;
        check("idle_ar_valid", 64'(bus.o_ar_valid), 64'd0);
        step();

        // Sequential fetches
        do_addr(64'h8000_0000); do_data(32'h0000_0013); do_out(64'h8000_0000, 32'h0000_0013);
        do_addr(64'h8000_0004); do_data(32'h0000_0013); do_out(64'h8000_0004, 32'h0000_0013);
        do_addr(64'h8000_0008); do_data(32'h0000_0013); do_out(64'h8000_0008, 32'h0000_0013);

        // Decode stall for 5 cycles in OUT
        do_addr(64'h8000_000C);
        do_data(32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            check("stall_inst_valid", 64'(bus.o_inst_valid), 64'd1);
            check("stall_inst", 64'(bus.o_inst), 64'h1234_5678);
            check("stall_pc", bus.o_pc, 64'h8000_000C);
            check("stall_no_ar", 64'(bus.o_ar_valid), 64'd0);
            step();
        end
        do_out(64'h8000_000C, 32'h1234_5678);

        // Redirect during DATA, data two cycles later is dropped
        do_addr(64'h8000_0010);
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 64'h8000_0100;
        check("flush_r_ready", 64'(bus.o_r_ready), 64'd1);
        step();
        bus.i_redirect = 1'b0;
        check("flush_wait_r_ready", 64'(bus.o_r_ready), 64'd1);
        step();
        bus.i_r_valid = 1'b1;
        bus.i_r_data  = 32'hdead_beef;
        step();
        bus.i_r_valid = 1'b0;
        check("flush_no_inst_valid", 64'(bus.o_inst_valid), 64'd0);
        check("flush_inst_not_dead", 64'(bus.o_inst == 32'hdead_beef), 64'd0);
        do_addr(64'h8000_0100); do_data(32'h1111_1111); do_out(64'h8000_0100, 32'h1111_1111);

        // Redirect in OUT with decode ready in the same cycle
        do_addr(64'h8000_0104);
        do_data(32'h2222_2222);
        check("out_redir_inst_valid", 64'(bus.o_inst_valid), 64'd1);
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 64'h8000_0200;
        bus.i_inst_ready  = 1'b1;
        step();
        bus.i_redirect   = 1'b0;
        bus.i_inst_ready = 1'b0;
        check("out_redir_drop", 64'(bus.o_inst_valid), 64'd0);
        check("out_redir_ar_valid", 64'(bus.o_ar_valid), 64'd1);
        check("out_redir_addr", bus.o_ar_addr, 64'h8000_0200);

        // Redirect in ADDR without handshake: still requesting, new address
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 64'h8000_0300;
        step();
        bus.i_redirect = 1'b0;
        check("addr_redir_ar_valid", 64'(bus.o_ar_valid), 64'd1);
        check("addr_redir_addr", bus.o_ar_addr, 64'h8000_0300);

        // Redirect coincident with the address handshake: returned data dropped
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 64'h8000_0400;
        bus.i_ar_ready    = 1'b1;
        step();
        bus.i_redirect = 1'b0;
        bus.i_ar_ready = 1'b0;
        check("hs_redir_r_ready", 64'(bus.o_r_ready), 64'd1);
        bus.i_r_valid = 1'b1;
        bus.i_r_data  = 32'hcafe_f00d;
        step();
        bus.i_r_valid = 1'b0;
        check("hs_redir_no_inst", 64'(bus.o_inst_valid), 64'd0);
        check("hs_redir_addr", bus.o_ar_addr, 64'h8000_0400);

        // pc+4 wraps from all-ones-minus-3 to zero
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        bus.i_redirect = 1'b0;
        do_addr(64'hFFFF_FFFF_FFFF_FFFC); do_data(32'h3333_3333); do_out(64'hFFFF_FFFF_FFFF_FFFC, 32'h3333_3333);
        check("wrap_addr", bus.o_ar_addr, 64'd0);

        // Reset during DATA; late data ignored
        do_addr(64'd0);
        rst = 1'b1;
        step();
        rst           = 1'b0;
        bus.i_r_valid = 1'b1;
        bus.i_r_data  = 32'h0bad_0bad;
        check("midrst_r_ready", 64'(bus.o_r_ready), 64'd0);
        check("midrst_ar_valid", 64'(bus.o_ar_valid), 64'd0);
        step();
        bus.i_r_valid = 1'b0;
        check("midrst_inst_valid", 64'(bus.o_inst_valid), 64'd0);
        do_addr(64'h8000_0000); do_data(32'h0000_0013); do_out(64'h8000_0000, 32'h0000_0013);

        // Misaligned redirect target
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 64'h8000_0002;
        step();
        bus.i_redirect = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
        check("mis_err", 64'(bus.o_fetch_err), 64'd1);
        check("mis_ar_valid", 64'(bus.o_ar_valid), 64'd0);
        bus.i_ar_ready = 1'b1;
        step();
        bus.i_ar_ready = 1'b0;
        check("mis_err_sticky", 64'(bus.o_fetch_err), 64'd1);
        check("mis_still_stalled", 64'(bus.o_ar_valid), 64'd0);
`else
        check("mis_err_tied", 64'(bus.o_fetch_err), 64'd0);
        check("mis_ar_valid", 64'(bus.o_ar_valid), 64'd1);
        check("mis_addr_as_is", bus.o_ar_addr, 64'h8000_0002);
`endif
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 64'h8000_0010;
        step();
        bus.i_redirect = 1'b0;
        check("align_err_clear", 64'(bus.o_fetch_err), 64'd0);
        do_addr(64'h8000_0010); do_data(32'h4444_4444); do_out(64'h8000_0010, 32'h4444_4444);
        check("final_addr", bus.o_ar_addr, 64'h8000_0014);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
